// File: rtl/compressor_square18_if.sv
// Operand/result bundle for compressor_square18: eighteen 18-bit operands in,
// 23 individual result bits out.
interface compressor_square18_if;
  logic [17:0] src0, src1, src2, src3, src4, src5, src6, src7, src8;
  logic [17:0] src9, src10, src11, src12, src13, src14, src15, src16, src17;
  logic dst0, dst1, dst2, dst3, dst4, dst5, dst6, dst7, dst8, dst9, dst10, dst11;
  logic dst12, dst13, dst14, dst15, dst16, dst17, dst18, dst19, dst20, dst21, dst22;

  // Operand source: drives the matrix, observes the sum bits.
  modport master (
    output src0, src1, src2, src3, src4, src5, src6, src7, src8,
    output src9, src10, src11, src12, src13, src14, src15, src16, src17,
    input  dst0, dst1, dst2, dst3, dst4, dst5, dst6, dst7, dst8, dst9, dst10, dst11,
    input  dst12, dst13, dst14, dst15, dst16, dst17, dst18, dst19, dst20, dst21, dst22
  );

  // Compressor side: consumes the matrix, drives the sum bits.
  modport slave (
    input  src0, src1, src2, src3, src4, src5, src6, src7, src8,
    input  src9, src10, src11, src12, src13, src14, src15, src16, src17,
    output dst0, dst1, dst2, dst3, dst4, dst5, dst6, dst7, dst8, dst9, dst10, dst11,
    output dst12, dst13, dst14, dst15, dst16, dst17, dst18, dst19, dst20, dst21, dst22
  );
endinterface

// File: rtl/compressor_square18.sv
// compressor_square18: sums eighteen 18-bit unsigned operands into a registered
// 23-bit result through a carry-save tree (18->12->8->6->4->3->2 rows) and a
// final carry-propagate adder. One cycle latency, one result per cycle.

// One row of 3:2 full adders across all columns. Column k's carry lands in
// column k+1. The carry out of the top column is not built: every row total is
// bounded by the final sum, which always fits in W bits.
module compressor_square18_csa #(
  parameter int W = 23
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] co
);
  assign co[0] = 1'b0;
  for (genvar k = 0; k < W; k++) begin : g_fa
    assign s[k] = a[k] ^ b[k] ^ c[k];
    if (k < W-1) begin : g_cy
      assign co[k+1] = (a[k] & b[k]) | (a[k] & c[k]) | (b[k] & c[k]);
    end
  end
endmodule

module compressor_square18 (
  input  logic                    clk,
  input  logic                    rst_n,
  compressor_square18_if.slave    bus
);
  localparam int SUM_W  = 23;
  localparam int STAGES = 6;
  localparam int TOT    = 53;
  // Row count entering each level, and where that level starts in the flat row store.
  localparam int ROWS [7] = '{18, 12, 8, 6, 4, 3, 2};
  localparam int OFF  [7] = '{0, 18, 30, 38, 44, 48, 51};

  logic [SUM_W-1:0] row [TOT];
  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] sum_q;

  // Level 0: operands zero-extended into the 23-bit column space.
  assign row[0]  = {5'd0, bus.src0};
  assign row[1]  = {5'd0, bus.src1};
  assign row[2]  = {5'd0, bus.src2};
  assign row[3]  = {5'd0, bus.src3};
  assign row[4]  = {5'd0, bus.src4};
  assign row[5]  = {5'd0, bus.src5};
  assign row[6]  = {5'd0, bus.src6};
  assign row[7]  = {5'd0, bus.src7};
  assign row[8]  = {5'd0, bus.src8};
  assign row[9]  = {5'd0, bus.src9};
  assign row[10] = {5'd0, bus.src10};
  assign row[11] = {5'd0, bus.src11};
  assign row[12] = {5'd0, bus.src12};
  assign row[13] = {5'd0, bus.src13};
  assign row[14] = {5'd0, bus.src14};
  assign row[15] = {5'd0, bus.src15};
  assign row[16] = {5'd0, bus.src16};
  assign row[17] = {5'd0, bus.src17};

  // Each level compresses rows in groups of three; the 1-2 leftover rows pass
  // straight through to the next level.
  for (genvar l = 0; l < STAGES; l++) begin : g_lvl
    localparam int G = ROWS[l] / 3;
    localparam int R = ROWS[l] % 3;
    localparam int I = OFF[l];
    localparam int O = OFF[l+1];
    for (genvar g = 0; g < G; g++) begin : g_csa
      compressor_square18_csa #(.W(SUM_W)) u_csa (
        .a  (row[I+3*g]),
        .b  (row[I+3*g+1]),
        .c  (row[I+3*g+2]),
        .s  (row[O+2*g]),
        .co (row[O+2*g+1])
      );
    end
    for (genvar r = 0; r < R; r++) begin : g_pass
      assign row[O+2*G+r] = row[I+3*G+r];
    end
  end

  // Final carry-propagate adder over the last two rows.
  assign sum_c = row[TOT-2] + row[TOT-1];

  // Output register: async clear, captures a fresh sum every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum_c;
  end

  assign bus.dst0  = sum_q[0];  assign bus.dst1  = sum_q[1];
  assign bus.dst2  = sum_q[2];  assign bus.dst3  = sum_q[3];
  assign bus.dst4  = sum_q[4];  assign bus.dst5  = sum_q[5];
  assign bus.dst6  = sum_q[6];  assign bus.dst7  = sum_q[7];
  assign bus.dst8  = sum_q[8];  assign bus.dst9  = sum_q[9];
  assign bus.dst10 = sum_q[10]; assign bus.dst11 = sum_q[11];
  assign bus.dst12 = sum_q[12]; assign bus.dst13 = sum_q[13];
  assign bus.dst14 = sum_q[14]; assign bus.dst15 = sum_q[15];
  assign bus.dst16 = sum_q[16]; assign bus.dst17 = sum_q[17];
  assign bus.dst18 = sum_q[18]; assign bus.dst19 = sum_q[19];
  assign bus.dst20 = sum_q[20]; assign bus.dst21 = sum_q[21];
  assign bus.dst22 = sum_q[22];
endmodule

// File: tb/tb_compressor_square18.sv
// Bench for compressor_square18: directed vector table, async reset cases and
// a randomized run against a plain-arithmetic sum model.
module tb_compressor_square18;
  logic clk;
  logic rst_n;
  logic [17:0] src_v [18];
  logic [22:0] dst_v;
  int checks;
  int failures;

  compressor_square18_if ifc ();

  compressor_square18 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  assign ifc.src0  = src_v[0];  assign ifc.src1  = src_v[1];  assign ifc.src2  = src_v[2];
  assign ifc.src3  = src_v[3];  assign ifc.src4  = src_v[4];  assign ifc.src5  = src_v[5];
  assign ifc.src6  = src_v[6];  assign ifc.src7  = src_v[7];  assign ifc.src8  = src_v[8];
  assign ifc.src9  = src_v[9];  assign ifc.src10 = src_v[10]; assign ifc.src11 = src_v[11];
  assign ifc.src12 = src_v[12]; assign ifc.src13 = src_v[13]; assign ifc.src14 = src_v[14];
  assign ifc.src15 = src_v[15]; assign ifc.src16 = src_v[16]; assign ifc.src17 = src_v[17];

  assign dst_v = {ifc.dst22, ifc.dst21, ifc.dst20, ifc.dst19, ifc.dst18, ifc.dst17,
                  ifc.dst16, ifc.dst15, ifc.dst14, ifc.dst13, ifc.dst12, ifc.dst11,
                  ifc.dst10, ifc.dst9, ifc.dst8, ifc.dst7, ifc.dst6, ifc.dst5,
                  ifc.dst4, ifc.dst3, ifc.dst2, ifc.dst1, ifc.dst0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0][17:0] ops;
    logic [22:0]       exp;
  } vec_t;

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
    end
  endtask

  // Reference: the arithmetic sum of whatever operands are currently driven.
  function automatic logic [22:0] ref_sum();
    int unsigned s;
    s = 0;
    for (int i = 0; i < 18; i++) s += int'(src_v[i]);
    return s[22:0];
  endfunction

  task automatic drive_rand();
    for (int i = 0; i < 18; i++) src_v[i] = 18'($urandom);
  endtask

  task automatic drive_all(input logic [17:0] v);
    for (int i = 0; i < 18; i++) src_v[i] = v;
  endtask

  vec_t  tbl [5];
  string tname [5];
  logic [22:0] exp_q;

  initial begin
    checks   = 0;
    failures = 0;

    // Directed table with hand-derived sums.
    for (int t = 0; t < 5; t++) tbl[t] = '0;
    tname[0] = "all_zero";   tbl[0].exp = 23'h000000;
    tname[1] = "src0_one";   tbl[1].ops[0] = 18'h00001;  tbl[1].exp = 23'h000001;
    tname[2] = "src17_max";  tbl[2].ops[17] = 18'h3FFFF; tbl[2].exp = 23'h03FFFF;
    tname[3] = "ramp";       for (int n = 0; n < 18; n++) tbl[3].ops[n] = 18'(n);
                             tbl[3].exp = 23'h000099;
    tname[4] = "full_scale"; for (int n = 0; n < 18; n++) tbl[4].ops[n] = 18'h3FFFF;
                             tbl[4].exp = 23'h47FFEE;

    // Reset held with random operands and a running clock.
    rst_n = 1'b0;
    drive_rand();
    #1 check("reset_async_clear", dst_v, 23'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); drive_rand();
      @(posedge clk); #1 check("reset_hold", dst_v, 23'h0);
    end

    // Release, then walk the table.
    @(negedge clk); rst_n = 1'b1; drive_all(18'h0);
    @(posedge clk); #1 check("release_zero", dst_v, 23'h0);
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      for (int i = 0; i < 18; i++) src_v[i] = tbl[t].ops[i];
      @(posedge clk); #1 check(tname[t], dst_v, tbl[t].exp);
    end
    check("bit22_full", {22'd0, ifc.dst22}, 23'd1);
    check("bit0_full",  {22'd0, ifc.dst0},  23'd0);

    // Output holds between edges while inputs change.
    @(negedge clk); drive_all(18'h0);
    #2 check("hold_between_edges", dst_v, 23'h47FFEE);

    // Randomized back-to-back operands.
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (c % 4 == 0) drive_all(18'($urandom_range(0, 1) ? 18'h3FFFF : 18'h0));
      else drive_rand();
      exp_q = ref_sum();
      @(posedge clk); #1 check("random", dst_v, exp_q);
    end

    // Async reset pulse mid-stream on the full-scale pattern.
    @(negedge clk); drive_all(18'h3FFFF);
    @(posedge clk); #1 check("fs_before_pulse", dst_v, 23'h47FFEE);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 check("pulse_clears_async", dst_v, 23'h0);
    #1 rst_n = 1'b1;
    #1 check("no_stale_after_release", dst_v, 23'h0);
    @(posedge clk); #1 check("fs_after_release", dst_v, 23'h47FFEE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
